fpdiv_ctrl: RTL and testbench

- Sequencing controller for the Goldschmidt divider datapath.
- Captures operands on a start handshake and drives the datapath operand buses, mux selects and A/B/C register enables for the initial-approximation step and ITERS refinement iterations.
- Captures the final quotient mantissa and signals completion with a one-cycle done pulse.
- Sits directly upstream of, and wraps the control of, the divider datapath.

---
 rtl/fpdiv_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fpdiv_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath.
// Captures operands on a start handshake, then steps the datapath through
// one initial-approximation step and ITERS refinement iterations. At the end
// it captures the quotient mantissa and pulses done for one cycle.
// Optional feature macro: FPDIV_CTRL_DIV0_EN adds the div0 output. When the
// captured divisor is zero, the sequence is bypassed and an all-ones
// quotient is returned.
module fpdiv_ctrl #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned QW    = 23,
  parameter int unsigned ITERS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] denom_in,
  input  logic             flush,
  input  logic [QW-1:0]    q_in,
  output logic             ready,
  output logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] denom,
  output logic             sel_mux2,
  output logic [1:0]       sel_mux4,
  output logic             en_a,
  output logic             en_b,
  output logic             en_c,
  output logic             done,
  output logic [QW-1:0]    q_out
`ifdef FPDIV_CTRL_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    DONE   = 3'd5
`ifdef FPDIV_CTRL_DIV0_EN
    ,
    ZERO   = 3'd6
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   num_q, num_d;
  logic [WIDTH-1:0]   denom_q, denom_d;
  logic [QW-1:0]      q_q, q_d;
  logic               ready_q, ready_d;
  logic               sel_mux2_q, sel_mux2_d;
  logic [1:0]         sel_mux4_q, sel_mux4_d;
  logic               en_a_q, en_a_d;
  logic               en_b_q, en_b_d;
  logic               en_c_q, en_c_d;
  logic               done_q, done_d;
`ifdef FPDIV_CTRL_DIV0_EN
  logic               div0_q, div0_d;
`endif

  // Next-state, datapath capture and Moore output decode of the next state.
  // Outputs are decoded from state_d so that the registered copies line up
  // with the state they belong to.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    denom_d    = denom_q;
    q_d        = q_q;
    ready_d    = 1'b0;
    sel_mux2_d = 1'b0;
    sel_mux4_d = 2'd0;
    en_a_d     = 1'b0;
    en_b_d     = 1'b0;
    en_c_d     = 1'b0;
    done_d     = 1'b0;
`ifdef FPDIV_CTRL_DIV0_EN
    div0_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_in;
          denom_d = denom_in;
          cnt_d   = '0;
          state_d = INIT_D;
`ifdef FPDIV_CTRL_DIV0_EN
          if (denom_in == '0) state_d = ZERO;
`endif
        end
      end
      INIT_D: state_d = INIT_N;
      INIT_N: state_d = ITER_N;
      ITER_N: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(ITERS)) begin
          state_d = DONE;
          q_d     = q_in;
        end else begin
          state_d = ITER_D;
        end
      end
      ITER_D: state_d = ITER_N;
      DONE:   state_d = IDLE;
`ifdef FPDIV_CTRL_DIV0_EN
      ZERO: begin
        state_d = DONE;
        q_d     = '1;
        div0_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Abort: back to IDLE with the previous quotient untouched
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      q_d     = q_q;
`ifdef FPDIV_CTRL_DIV0_EN
      div0_d  = 1'b0;
`endif
    end

    unique case (state_d)
      IDLE:   ready_d = 1'b1;
      INIT_D: begin
        sel_mux4_d = 2'd1;
        en_b_d     = 1'b1;
        en_c_d     = 1'b1;
      end
      INIT_N: begin
        sel_mux4_d = 2'd0;
        en_a_d     = 1'b1;
      end
      ITER_N: begin
        sel_mux2_d = 1'b1;
        sel_mux4_d = 2'd2;
        en_a_d     = 1'b1;
      end
      ITER_D: begin
        sel_mux2_d = 1'b1;
        sel_mux4_d = 2'd3;
        en_b_d     = 1'b1;
        en_c_d     = 1'b1;
      end
      DONE:   done_d = 1'b1;
      default: ;
    endcase
  end

  // State, operand, quotient and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      denom_q    <= '0;
      q_q        <= '0;
      ready_q    <= 1'b1;
      sel_mux2_q <= 1'b0;
      sel_mux4_q <= 2'd0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_c_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FPDIV_CTRL_DIV0_EN
      div0_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      denom_q    <= denom_d;
      q_q        <= q_d;
      ready_q    <= ready_d;
      sel_mux2_q <= sel_mux2_d;
      sel_mux4_q <= sel_mux4_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      en_c_q     <= en_c_d;
      done_q     <= done_d;
`ifdef FPDIV_CTRL_DIV0_EN
      div0_q     <= div0_d;
`endif
    end
  end

  assign ready    = ready_q;
  assign num      = num_q;
  assign denom    = denom_q;
  assign sel_mux2 = sel_mux2_q;
  assign sel_mux4 = sel_mux4_q;
  assign en_a     = en_a_q;
  assign en_b     = en_b_q;
  assign en_c     = en_c_q;
  assign done     = done_q;
  assign q_out    = q_q;
`ifdef FPDIV_CTRL_DIV0_EN
  assign div0     = div0_q;
`endif

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed testbench for fpdiv_ctrl (ITERS=3).
module tb_fpdiv_ctrl;

  localparam int unsigned WIDTH = 26;
  localparam int unsigned QW    = 23;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] num_in;
  logic [WIDTH-1:0] denom_in;
  logic             flush;
  logic [QW-1:0]    q_in;
  logic             ready;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] denom;
  logic             sel_mux2;
  logic [1:0]       sel_mux4;
  logic             en_a;
  logic             en_b;
  logic             en_c;
  logic             done;
  logic [QW-1:0]    q_out;
`ifdef FPDIV_CTRL_DIV0_EN
  logic             div0;
`endif

  int n_vec;
  int n_err;
  logic [5:0] exp_seq [7];

  fpdiv_ctrl #(.WIDTH(WIDTH), .QW(QW), .ITERS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_in   (num_in),
    .denom_in (denom_in),
    .flush    (flush),
    .q_in     (q_in),
    .ready    (ready),
    .num      (num),
    .denom    (denom),
    .sel_mux2 (sel_mux2),
    .sel_mux4 (sel_mux4),
    .en_a     (en_a),
    .en_b     (en_b),
    .en_c     (en_c),
    .done     (done),
    .q_out    (q_out)
`ifdef FPDIV_CTRL_DIV0_EN
    ,
    .div0     (div0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return 32'({sel_mux2, sel_mux4, en_a, en_b, en_c});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_seq[0] = 6'b0_01_011;
    exp_seq[1] = 6'b0_00_100;
    exp_seq[2] = 6'b1_10_100;
    exp_seq[3] = 6'b1_11_011;
    exp_seq[4] = 6'b1_10_100;
    exp_seq[5] = 6'b1_11_011;
    exp_seq[6] = 6'b1_10_100;

    reset    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    num_in   = '0;
    denom_in = '0;
    q_in     = 23'h00_0123;

    // Reset for two cycles, then release
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ctl", ctl(), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_ctl", ctl(), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_q", 32'(q_out), 32'd0);

    // Nominal run
    num_in   = 26'h0C0_0000;
    denom_in = 26'h100_0000;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("nom_num", 32'(num), 32'h00C0_0000);
    chk("nom_denom", 32'(denom), 32'h0100_0000);
    chk("nom_busy", 32'(ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("nom_seq%0d", i), ctl(), 32'(exp_seq[i]));
      chk($sformatf("nom_nodone%0d", i), 32'(done), 32'd0);
      if (i == 6) q_in = 23'h2A_AAAA;
      step();
    end
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_q", 32'(q_out), 32'h002A_AAAA);
    chk("nom_done_ctl", ctl(), 32'd0);
    chk("nom_done_ready", 32'(ready), 32'd0);
    step();
    chk("nom_done_pulse", 32'(done), 32'd0);
    chk("nom_ready", 32'(ready), 32'd1);
    chk("nom_q_hold", 32'(q_out), 32'h002A_AAAA);

    // Busy start: start held across a full run
    q_in   = 23'h15_5555;
    num_in = 26'h123_4567;
    start  = 1'b1;
    step();
    num_in = 26'h0AB_CDEF;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("busy_num%0d", i), 32'(num), 32'h0123_4567);
      chk($sformatf("busy_seq%0d", i), ctl(), 32'(exp_seq[i]));
      step();
    end
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_q", 32'(q_out), 32'h0015_5555);
    chk("busy_num_done", 32'(num), 32'h0123_4567);
    step();
    chk("busy_idle_ready", 32'(ready), 32'd1);
    chk("busy_idle_num", 32'(num), 32'h0123_4567);
    step();
    start = 1'b0;
    chk("busy_accept_num", 32'(num), 32'h00AB_CDEF);
    chk("busy_accept_ctl", ctl(), 32'(exp_seq[0]));

    // Flush in the 2nd ITER_D of that second run
    q_in = 23'h00_0007;
    for (int i = 1; i < 6; i++) step();
    chk("fl_in_iter_d", ctl(), 32'(exp_seq[5]));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ready", 32'(ready), 32'd1);
    chk("fl_ctl", ctl(), 32'd0);
    chk("fl_done", 32'(done), 32'd0);
    chk("fl_q", 32'(q_out), 32'h0015_5555);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_nodone%0d", i), 32'(done), 32'd0);
      chk($sformatf("fl_idle%0d", i), 32'(ready), 32'd1);
    end

    // Flush in IDLE together with start: start wins
    num_in = 26'h055_5555;
    start  = 1'b1;
    flush  = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("flst_num", 32'(num), 32'h0055_5555);
    chk("flst_ctl", ctl(), 32'(exp_seq[0]));

    // Async reset between edges in INIT_N
    step();
    chk("ar_init_n", ctl(), 32'(exp_seq[1]));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ready", 32'(ready), 32'd1);
    chk("ar_ctl", ctl(), 32'd0);
    chk("ar_num", 32'(num), 32'd0);
    chk("ar_q", 32'(q_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("ar_post_ready", 32'(ready), 32'd1);
    chk("ar_post_done", 32'(done), 32'd0);

`ifdef FPDIV_CTRL_DIV0_EN
    // Zero divisor bypass
    num_in   = 26'h0C0_0000;
    denom_in = '0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("d0_ctl0", ctl(), 32'd0);
    chk("d0_nodone", 32'(done), 32'd0);
    step();
    chk("d0_done", 32'(done), 32'd1);
    chk("d0_flag", 32'(div0), 32'd1);
    chk("d0_q", 32'(q_out), 32'h007F_FFFF);
    chk("d0_ctl1", ctl(), 32'd0);
    step();
    chk("d0_done_pulse", 32'(done), 32'd0);
    chk("d0_flag_clr", 32'(div0), 32'd0);
    chk("d0_ready", 32'(ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
